raster_tri_dispatcher: RTL and testbench

// Queues incoming screen-space triangles and issues them one at a time to the rasterizer, holding all vertex

---
 rtl/raster_pkg.sv | 32 +++
 rtl/raster_tri_dispatcher_if.sv | 28 ++
 rtl/raster_tri_fifo.sv | 63 ++++++
 rtl/raster_tri_dispatcher.sv | 154 +++++++++++++++
 tb/tb_raster_tri_dispatcher.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/raster_pkg.sv
// Shared types for the triangle dispatcher: triangle layout, queue entry, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package raster_pkg;

    localparam int TRI_W = 360;
    localparam logic [31:0] FP_ONE = 32'h0001_0000;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } vertex_t;

    // Packs MSB-first as {x1,y1,z1,x2,y2,z2,x3,y3,z3,color1,color2,color3}.
    typedef struct packed {
        vertex_t     v1;
        vertex_t     v2;
        vertex_t     v3;
        logic [23:0] color1;
        logic [23:0] color2;
        logic [23:0] color3;
    } tri_t;

    typedef struct packed {
        logic last;
        tri_t data;
    } fifo_ent_t;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RUN, DONE} disp_state_e;

endpackage

// File: rtl/raster_tri_dispatcher_if.sv
// Upstream triangle handshake plus rasterizer-facing drive/stall signals.
// Latency: n/a (wiring only).
// Backpressure: tri_ready from dispatcher, ras_busy from rasterizer.
interface raster_tri_dispatcher_if
    import raster_pkg::*;
#(
    parameter int ADDR_W = 26
) ();
    logic              tri_valid;
    logic              tri_ready;
    tri_t              tri_data;
    logic              tri_last;
    logic              ras_valid;
    tri_t              ras_tri;
    logic [ADDR_W-1:0] ras_addr;
    logic              ras_done;
    logic              ras_busy;

    modport master (
        output tri_valid, tri_data, tri_last, ras_busy,
        input  tri_ready, ras_valid, ras_tri, ras_addr, ras_done
    );

    modport slave (
        input  tri_valid, tri_data, tri_last, ras_busy,
        output tri_ready, ras_valid, ras_tri, ras_addr, ras_done
    );
endinterface

// File: rtl/raster_tri_fifo.sv
// Synchronous FIFO with occupancy count; head_dat shows the oldest entry.
// Latency: push visible at head/count one cycle later.
// Backpressure: push ignored when full, pop ignored when empty.
module raster_tri_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != FULL_CNT);
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/raster_tri_dispatcher.sv
// Queues triangles and issues one at a time to the rasterizer, holding inputs stable; optional RASTER_STATS_EN counters.
// Latency: 2 cycles from first enqueue to ras_valid (IDLE->LOAD->ISSUE), 3-cycle turnaround after ras_busy falls.
// Backpressure: tri_ready low when queue full (registered count) or frame closed; stalls in ISSUE/RUN per ras_busy.
module raster_tri_dispatcher
    import raster_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] frame_base,
    raster_tri_dispatcher_if.slave tri_if,
    output logic              frame_done,
    output logic              busy
`ifdef RASTER_STATS_EN
    ,
    output logic [31:0]       stat_tris,
    output logic [31:0]       stat_cycles
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    disp_state_e       state_q, state_d;
    logic              frame_open_q, frame_open_d;
    logic [ADDR_W-1:0] ras_addr_q, ras_addr_d;
    tri_t              ras_tri_q, ras_tri_d;
    logic              ras_done_q, ras_done_d;

    logic [CW-1:0]     fifo_count;
    fifo_ent_t         head;
    fifo_ent_t         push_ent;
    logic              tri_ready, push, pop, start_acc, ras_valid;

    assign tri_ready = frame_open_q && (fifo_count != FULL_CNT);
    assign push      = tri_if.tri_valid && tri_ready;
    assign start_acc = frame_start && (state_q == IDLE) && (fifo_count == '0);
    assign push_ent  = '{last: tri_if.tri_last, data: tri_if.tri_data};

    raster_tri_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fifo_ent_t))
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        frame_open_d = frame_open_q;
        ras_addr_d   = ras_addr_q;
        ras_tri_d    = ras_tri_q;
        ras_done_d   = ras_done_q;
        pop          = 1'b0;
        ras_valid    = 1'b0;
        frame_done   = 1'b0;

        if (start_acc) begin
            frame_open_d = 1'b1;
            ras_addr_d   = frame_base;
        end
        if (push && tri_if.tri_last) begin
            frame_open_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fifo_count != '0) state_d = LOAD;
            end
            LOAD: begin
                pop        = 1'b1;
                ras_tri_d  = head.data;
                ras_done_d = head.last;
                state_d    = ISSUE;
            end
            // Completion needs busy seen high first, so a low busy here just waits.
            ISSUE: begin
                ras_valid = 1'b1;
                if (tri_if.ras_busy) state_d = RUN;
            end
            RUN: begin
                ras_valid = 1'b1;
                if (!tri_if.ras_busy) state_d = DONE;
            end
            DONE: begin
                frame_done = ras_done_q;
                state_d    = (fifo_count != '0) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            frame_open_q <= 1'b0;
            ras_addr_q   <= '0;
            ras_tri_q    <= '0;
            ras_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_open_q <= frame_open_d;
            ras_addr_q   <= ras_addr_d;
            ras_tri_q    <= ras_tri_d;
            ras_done_q   <= ras_done_d;
        end
    end

    assign tri_if.tri_ready = tri_ready;
    assign tri_if.ras_valid = ras_valid;
    assign tri_if.ras_tri   = ras_tri_q;
    assign tri_if.ras_addr  = ras_addr_q;
    assign tri_if.ras_done  = ras_done_q;
    assign busy = frame_open_q || (fifo_count != '0) || (state_q != IDLE);

`ifdef RASTER_STATS_EN
    logic [31:0] stat_tris_q, stat_tris_d;
    logic [31:0] stat_cycles_q, stat_cycles_d;

    always_comb begin
        stat_tris_d   = stat_tris_q;
        stat_cycles_d = stat_cycles_q;
        if (start_acc) begin
            stat_tris_d   = '0;
            stat_cycles_d = '0;
        end else begin
            if ((state_q == DONE) && (stat_tris_q != '1)) stat_tris_d = stat_tris_q + 32'd1;
            if (((state_q == ISSUE) || (state_q == RUN)) && (stat_cycles_q != '1))
                stat_cycles_d = stat_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_tris_q   <= '0;
            stat_cycles_q <= '0;
        end else begin
            stat_tris_q   <= stat_tris_d;
            stat_cycles_q <= stat_cycles_d;
        end
    end

    assign stat_tris   = stat_tris_q;
    assign stat_cycles = stat_cycles_q;
`endif

endmodule

// File: tb/tb_raster_tri_dispatcher.sv
// Directed bench for raster_tri_dispatcher with a simple rasterizer stall model.
module tb_raster_tri_dispatcher;
    import raster_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_start;
    logic [25:0] frame_base;
    logic        frame_done;
    logic        busy;
`ifdef RASTER_STATS_EN
    logic [31:0] stat_tris;
    logic [31:0] stat_cycles;
`endif

    always #5 clock = ~clock;

    raster_tri_dispatcher_if #(.ADDR_W(26)) ifc ();

    raster_tri_dispatcher #(.FIFO_DEPTH(4), .ADDR_W(26)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .frame_base  (frame_base),
        .tri_if      (ifc),
        .frame_done  (frame_done),
        .busy        (busy)
`ifdef RASTER_STATS_EN
        ,
        .stat_tris   (stat_tris),
        .stat_cycles (stat_cycles)
`endif
    );

    int errs = 0;
    int checks = 0;

    // Rasterizer model: raises busy for busy_len cycles once per issued triangle.
    logic bsy = 1'b0;
    logic seen = 1'b0;
    logic prev_valid = 1'b0;
    logic model_en = 1'b0;
    int   busy_len = 5;
    int   cnt = 0;
    int   cyc = 0;
    int   fall_cyc = -1;
    int   fd_cnt = 0;
    int   fd_cyc = 0;
    tri_t log_q[$];
    int   gap_q[$];

    assign ifc.ras_busy = bsy;

    always @(posedge clock) begin
        #1;
        cyc++;
        if (ifc.ras_valid && !prev_valid) begin
            log_q.push_back(ifc.ras_tri);
            if (fall_cyc >= 0) gap_q.push_back(cyc - fall_cyc);
        end
        prev_valid = ifc.ras_valid;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (bsy) begin
            cnt--;
            if (cnt == 0) begin
                bsy = 1'b0;
                fall_cyc = cyc;
            end
        end else if (model_en && ifc.ras_valid && !seen) begin
            bsy = 1'b1;
            cnt = busy_len;
            seen = 1'b1;
        end
        if (!ifc.ras_valid) seen = 1'b0;
    end

    function automatic tri_t mk_tri(input int k);
        tri_t t;
        t.v1.x = FP_ONE * 32'(k);
        t.v1.y = FP_ONE * 32'(k + 1);
        t.v1.z = 32'(k) ^ 32'hA5A5_0000;
        t.v2.x = FP_ONE * 32'(k + 2);
        t.v2.y = FP_ONE * 32'(k + 3);
        t.v2.z = 32'(k) ^ 32'h5A5A_0000;
        t.v3.x = FP_ONE * 32'(k + 4);
        t.v3.y = FP_ONE * 32'(k + 5);
        t.v3.z = 32'(k) ^ 32'h0F0F_0000;
        t.color1 = 24'h110000 + 24'(k);
        t.color2 = 24'h002200 + 24'(k);
        t.color3 = 24'h000033 + 24'(k);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tri(input string tag, input tri_t obs, input tri_t exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start(input logic [25:0] base);
        frame_base  = base;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    task automatic push_tri(input tri_t t, input logic last);
        int n = 0;
        while (!ifc.tri_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("push_ready", ifc.tri_ready, 1);
        ifc.tri_valid = 1'b1;
        ifc.tri_data  = t;
        ifc.tri_last  = last;
        @(negedge clock);
        ifc.tri_valid = 1'b0;
        ifc.tri_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ifc.ras_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk(tag, ifc.ras_valid, 1);
    endtask

    task automatic wait_fd(input string tag, input int target);
        int n = 0;
        while (fd_cnt < target && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk(tag, fd_cnt, target);
    endtask

    initial begin
        int fd0;
        frame_start   = 1'b0;
        frame_base    = '0;
        ifc.tri_valid = 1'b0;
        ifc.tri_data  = '0;
        ifc.tri_last  = 1'b0;

        // Power-on reset
        tick(3);
        chk("rst_valid", ifc.ras_valid, 0);
        chk("rst_ready", ifc.tri_ready, 0);
        chk("rst_addr", ifc.ras_addr, 0);
        chk("rst_done", ifc.ras_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fdone", frame_done, 0);
        reset = 1'b1;
        tick(2);

        // Single last triangle, 10-cycle rasterizer busy
        pulse_start(26'h100000);
        chk("t2_addr", ifc.ras_addr, 26'h100000);
        chk("t2_ready_open", ifc.tri_ready, 1);
        chk("t2_busy_open", busy, 1);
        busy_len = 10;
        model_en = 1'b1;
        fd0 = fd_cnt;
        push_tri(mk_tri(1), 1'b1);
        chk("t2_ready_closed", ifc.tri_ready, 0);
        wait_valid("t2_issue");
        chk("t2_ras_done_issue", ifc.ras_done, 1);
        chk_tri("t2_tri", ifc.ras_tri, mk_tri(1));
        tick(3);
        chk("t2_ras_done_run", ifc.ras_done, 1);
        chk("t2_valid_run", ifc.ras_valid, 1);
        wait_fd("t2_fdone", fd0 + 1);
        chk("t2_fdone_delay", fd_cyc - fall_cyc, 1);
        tick(3);
        chk("t2_fdone_width", fd_cnt, fd0 + 1);
        chk("t2_idle_busy", busy, 0);

        // Six triangles through a 4-deep queue, plus an ignored frame_start
        pulse_start(26'h0200000);
        log_q.delete();
        gap_q.delete();
        fall_cyc = -1;
        busy_len = 5;
        fd0 = fd_cnt;
        for (int i = 0; i < 5; i++) push_tri(mk_tri(10 + i), 1'b0);
        chk("t3_ready_full", ifc.tri_ready, 0);
        push_tri(mk_tri(15), 1'b1);
        pulse_start(26'h3ABCDE);
        chk("t5_addr_kept", ifc.ras_addr, 26'h0200000);
        chk("t5_ready_closed", ifc.tri_ready, 0);
        wait_fd("t3_fdone", fd0 + 1);
        chk("t3_issued", log_q.size(), 6);
        for (int i = 0; i < 6; i++) chk_tri($sformatf("t3_order%0d", i), log_q[i], mk_tri(10 + i));
        chk("t3_gaps", gap_q.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_gap%0d", i), gap_q[i], 3);

        // Rasterizer never raises busy: dispatcher must hold in ISSUE
        tick(2);
        pulse_start(26'h0300000);
        model_en = 1'b0;
        fd0 = fd_cnt;
        push_tri(mk_tri(20), 1'b1);
        wait_valid("t4_issue");
        tick(20);
        chk("t4_valid_held", ifc.ras_valid, 1);
        chk_tri("t4_tri_held", ifc.ras_tri, mk_tri(20));
        chk("t4_no_advance", fd_cnt, fd0);
        chk("t4_busy", busy, 1);
        busy_len = 3;
        model_en = 1'b1;
        wait_fd("t4_release", fd0 + 1);
        tick(2);

`ifdef RASTER_STATS_EN
        // Three triangles with 8 busy cycles each; one ISSUE cycle apiece
        pulse_start(26'h0400000);
        chk("t6_tris_clr", stat_tris, 0);
        chk("t6_cyc_clr", stat_cycles, 0);
        busy_len = 8;
        fd0 = fd_cnt;
        push_tri(mk_tri(30), 1'b0);
        push_tri(mk_tri(31), 1'b0);
        push_tri(mk_tri(32), 1'b1);
        wait_fd("t6_fdone", fd0 + 1);
        tick(2);
        chk("t6_tris", stat_tris, 3);
        chk("t6_cycles", stat_cycles, 27);
`endif

        // Reset asserted mid-RUN for three cycles
        pulse_start(26'h0500000);
        busy_len = 10;
        push_tri(mk_tri(40), 1'b1);
        wait_valid("t1_issue");
        tick(3);
        chk("t1_in_run", ifc.ras_busy, 1);
        fd0 = fd_cnt;
        reset = 1'b0;
        tick(3);
        model_en = 1'b0;
        chk("t1_valid", ifc.ras_valid, 0);
        chk("t1_ready", ifc.tri_ready, 0);
        chk("t1_addr", ifc.ras_addr, 0);
        chk("t1_done", ifc.ras_done, 0);
        chk_tri("t1_tri", ifc.ras_tri, '0);
        chk("t1_busy", busy, 0);
        chk("t1_fdone", frame_done, 0);
        reset = 1'b1;
        tick(15);
        chk("t1_no_pulse", fd_cnt, fd0);
        chk("t1_idle", busy, 0);
        chk("t1_idle_valid", ifc.ras_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
